carry_save_resolver: RTL and testbench
======================================

CARRY_SAVE_RESOLVER -- requirements
Module: carry_save_resolver

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each carry-save input vector.
REQ-002 Parameter CHUNK, default 4: bits resolved per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  carry-save pair on oo/ot is valid.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 oo  input  WIDTH  sum vector, weight 2^i per bit i.
REQ-008 ot  input  WIDTH  carry vector, weight 2^(i+1) per bit i.
REQ-009 out_valid  output  1  result holds a resolved value.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  WIDTH+2  binary value oo + (ot << 1), unsigned.
REQ-012 busy  output  1  high while resolution is in progress (state RUN).

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE); busy SHALL equal (state == RUN).
REQ-015 IDLE, in_valid high: latch oo and {ot[WIDTH-2:0],1'b0}, clear carry and chunk counter, go to RUN.
REQ-016 RUN: each cycle SHALL add chunk k of both latched operands plus stored carry, write CHUNK result bits at [k*CHUNK +: CHUNK], store carry-out, increment k.
REQ-017 On the final chunk (k = WIDTH/CHUNK-1) the block SHALL write result[WIDTH+1:WIDTH] = ot[WIDTH-1] + final carry-out and go to DONE.
REQ-018 Latency SHALL be exactly WIDTH/CHUNK cycles from the accepting edge to the first cycle with out_valid high (4 for defaults).
REQ-019 DONE: result and out_valid SHALL hold stable until out_ready is high; on that edge go to IDLE.
REQ-020 in_valid outside IDLE SHALL be ignored; oo/ot changes after acceptance SHALL not affect result.
REQ-021 out_ready outside DONE SHALL be ignored.
REQ-022 Maximum throughput SHALL be one pair per WIDTH/CHUNK+2 cycles when out_ready is held high.
REQ-023 result bits not yet written during RUN are don't-care; only values under out_valid are defined.
REQ-024 WIDTH == CHUNK SHALL give a single RUN cycle with correct top bits.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, in_ready 1, out_valid 0, busy 0, result 0, carry 0, counter 0.
REQ-026 Reset during RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow reset release.
REQ-027 The first accept after reset release SHALL be possible on the first rising edge with rst_n high.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and a function computing the chunk count WIDTH/CHUNK and counter width.
REQ-029 A sub-module csr_chunk_add (CHUNK-bit adder, carry in/out, purely combinational) SHALL be instantiated once and reused every RUN cycle.
REQ-030 An elaboration-time check SHALL reject WIDTH not divisible by CHUNK.

Verification
REQ-031 Defaults, oo=16'h0001, ot=16'h0000, out_ready=1 -> result=18'h00001, out_valid after exactly 4 cycles, for 1 cycle.
REQ-032 oo=16'h000F, ot=16'h0001 -> result=18'h00011 (carry crosses chunk 0 into chunk 1).
REQ-033 oo=16'hFFFF, ot=16'hFFFF -> result=18'h2FFFD (full-width carry, top bits = 2'b10).
REQ-034 oo=16'h8000, ot=16'h4000, out_ready held 0 for 5 cycles -> result=18'h10000 stable, out_valid high throughout, in_ready 0; second pair presented meanwhile is not accepted.
REQ-035 rst_n pulsed low during the 2nd RUN cycle -> immediate IDLE, outputs at reset values, no out_valid; next pair oo=16'h0003, ot=16'h0002 -> result=18'h00007.
REQ-036 Back-to-back random pairs, out_ready random -> every result equals oo + 2*ot in accept order; none dropped or duplicated.

Source files
------------

// File: rtl/carry_save_resolver_pkg.sv
// Shared definitions for the carry-save resolver: FSM states and chunk sizing helpers.
package carry_save_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } csr_state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int chunk);
        return (width / chunk > 1) ? $clog2(width / chunk) : 1;
    endfunction

endpackage

// File: rtl/csr_chunk_add.sv
// CHUNK-bit ripple adder with carry in/out; one slice of the resolver datapath.
module csr_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign {co, s} = full;

endmodule

// File: rtl/carry_save_resolver.sv
// Resolves a carry-save pair (oo + 2*ot) to binary, CHUNK bits per clock through one shared adder.
module carry_save_resolver
    import carry_save_resolver_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] oo,
    input  logic [WIDTH-1:0] ot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result,
    output logic             busy
);

    localparam int N_CHUNK = chunk_count(WIDTH, CHUNK);
    localparam int CNT_W   = cnt_width(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_geometry
        $error("carry_save_resolver: WIDTH must be a multiple of CHUNK");
    end

    csr_state_t       state, next_state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             top_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    int               base;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;
    logic             accept;

    assign accept    = (state == ST_IDLE) && in_valid;
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign base      = int'(cnt_q) * CHUNK;

    csr_chunk_add #(.CHUNK(CHUNK)) u_add (
        .a  (a_q[base +: CHUNK]),
        .b  (b_q[base +: CHUNK]),
        .ci (carry_q),
        .s  (chunk_sum),
        .co (chunk_co)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid)       next_state = ST_RUN;
            ST_RUN:  if (cnt_q == LAST)  next_state = ST_DONE;
            ST_DONE: if (out_ready)      next_state = ST_IDLE;
            default:                     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Operands are captured once so later input changes cannot disturb the running sum.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= oo;
            b_q   <= {ot[WIDTH-2:0], 1'b0};
            top_q <= ot[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state == ST_RUN) begin
            result[base +: CHUNK] <= chunk_sum;
            carry_q               <= chunk_co;
            cnt_q                 <= cnt_q + CNT_W'(1);
            // The shifted-out carry MSB joins the final carry in the two extra result bits.
            if (cnt_q == LAST)
                result[WIDTH+1:WIDTH] <= {1'b0, top_q} + {1'b0, chunk_co};
        end
    end

endmodule

// File: tb/tb_carry_save_resolver.sv
// Self-checking bench for carry_save_resolver: directed corner pairs, reset abort, random handshake traffic.
module tb_carry_save_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] oo, ot;
    logic [17:0] result;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [7:0]  s_oo, s_ot;
    logic [9:0]  s_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    carry_save_resolver #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .oo(oo), .ot(ot), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    carry_save_resolver #(.WIDTH(8), .CHUNK(8)) u_dut_single (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .oo(s_oo), .ot(s_ot), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .busy(s_busy)
    );

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b);
        return 18'(a) + 18'(b) * 18'd2;
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b);
        return 10'(a) + 10'(b) * 10'd2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_pair(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [17:0] exp_r;
        int cyc;
        exp_r = model16(a, b);
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        oo = a; ot = b; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; oo = 16'($urandom); ot = 16'($urandom);
        chk("run_busy", busy, 1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 4);
        chk("result", result, exp_r);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; oo = 16'hAAAA; ot = 16'h5555;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, exp_r);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    logic [17:0] exp_q[$];

    initial begin
        int cyc, seen, sent, got;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_oo = '0; s_ot = '0;

        // Reset values, with a pair already waiting for the first edge after release.
        rst_n = 1'b0; in_valid = 1'b1; oo = 16'h0005; ot = 16'h0001; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_accept", busy, 1);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_result", result, model16(16'h0005, 16'h0001));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        do_pair(16'h0001, 16'h0000, 0);
        do_pair(16'h000F, 16'h0001, 0);
        do_pair(16'hFFFF, 16'hFFFF, 0);
        do_pair(16'h8000, 16'h4000, 5);

        // Abort in the second RUN cycle.
        @(negedge clk);
        oo = 16'h1234; ot = 16'h0F0F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_valid_after_abort", seen, 0);
        do_pair(16'h0003, 16'h0002, 0);

        // Random traffic with random consumer stalls.
        sent = 0; got = 0;
        for (int c = 0; c < 3000 && (sent < 40 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            in_valid  = (sent < 40) && ($urandom_range(3) != 0);
            oo        = 16'($urandom);
            ot        = 16'($urandom);
            out_ready = ($urandom_range(2) != 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(model16(oo, ot));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rnd_extra", 1, 0);
                else begin
                    chk("rnd_result", result, exp_q.pop_front());
                    got++;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rnd_count", got, 40);
        chk("rnd_left", exp_q.size(), 0);

        // Single-chunk instance: one RUN cycle, carry into the top bits.
        for (int i = 0; i < 8; i++) begin
            logic [9:0] e;
            @(negedge clk);
            s_oo = (i == 0) ? 8'hFF : 8'($urandom);
            s_ot = (i == 0) ? 8'hFF : 8'($urandom);
            e = model8(s_oo, s_ot);
            s_in_valid = 1'b1;
            @(negedge clk);
            s_in_valid = 1'b0;
            chk("single_busy", s_busy, 1);
            @(negedge clk);
            chk("single_valid", s_out_valid, 1);
            chk("single_result", s_result, e);
            s_out_ready = 1'b1;
            @(negedge clk);
            s_out_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
